uart_host_driver: RTL and testbench
===================================

// Module: uart_host_driver
// PURPOSE
//  Host-side UART peer for the pipelined CPU's serial port; used in system benches and the board self-test harness.
//  Serialises two operand bytes (A, then B) onto the CPU's uart_rx line, then receives the one-byte result the CPU
//  returns on uart_tx. Reports the result, a timeout, or a framing error. Format is 8N1, LSB first, idle-high.
// PARAMETERS
//  BAUD_DIV     5208     clk cycles per bit (50 MHz / 9600); must be >= 4
//  GAP_BITS     1        idle bit-times driven high between the stop bit of A and the start bit of B; 0 is allowed
//  TIMEOUT_CYC  2000000  max clk cycles allowed from the end of B's stop bit to the result start-bit falling edge
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  start      in   1  1-cycle request; sampled only in IDLE
//  operand_a  in   8  first byte sent; captured on an accepted start
//  operand_b  in   8  second byte sent; captured on an accepted start
//  host_tx    out  1  serial line to CPU uart_rx
//  host_rx    in   1  serial line from CPU uart_tx (asynchronous to clk)
//  busy       out  1  high from the cycle after an accepted start until the return to IDLE
//  done       out  1  1-cycle pulse; result valid
//  result     out  8  last correctly received byte; held until the next done
//  timeout    out  1  1-cycle pulse; no result start bit within TIMEOUT_CYC
//  frame_err  out  1  1-cycle pulse; result stop bit sampled low
// BEHAVIOUR
//  Reset values: host_tx=1, busy=0, done=0, result=8'h00, timeout=0, frame_err=0, state=IDLE, all counters 0.
//  - Reset is asynchronous: asserting rst mid-frame forces host_tx high immediately, which aborts the frame.
//  - host_rx passes through a 2-FF synchroniser that resets to 1; the receiver reads only the synchronised copy.
//  FSM: IDLE -> TX_A -> GAP -> TX_B -> WAIT_RX -> RX -> IDLE. When GAP_BITS=0, GAP is skipped.
//  - IDLE: on start=1, capture operand_a/operand_b and go to TX_A. start is ignored in every other state.
//  - TX_A/TX_B: each sends 10 bits (start=0, d[0]..d[7], stop=1). Each bit is held exactly BAUD_DIV cycles.
//    host_tx is registered. The first start bit appears the cycle after start is accepted.
//  - GAP: host_tx=1 for GAP_BITS*BAUD_DIV cycles.
//  - WAIT_RX: timeout counter clears on entry and increments every cycle. The receiver arms here only.
//    Line activity during TX states is ignored.
//    - A falling edge on the synchronised rx (1->0) moves to RX.
//    - If the counter reaches TIMEOUT_CYC-1 with no edge: pulse timeout and go to IDLE.
//  - RX: sample the line BAUD_DIV/2 cycles after the edge (integer division).
//    - Start bit sampled high = glitch: return to WAIT_RX. The timeout counter is NOT cleared and keeps counting.
//    - Otherwise sample 8 data bits, LSB first, each BAUD_DIV cycles after the previous sample.
//    - Stop bit is sampled at the same spacing.
//    - Stop=1: load result and pulse done in the same cycle, go to IDLE.
//    - Stop=0: pulse frame_err, leave result unchanged, go to IDLE. The next start is accepted only once the line
//      has been seen high; until then start is ignored.
//  - busy is low in the cycle done/timeout/frame_err pulses, so start may be accepted in the next cycle.
//  - At most one of done/timeout/frame_err pulses per transaction. A transaction is never re-sent automatically.
//  - Counters: the bit-time counter is wide enough for BAUD_DIV-1. The timeout counter is wide enough for
//    TIMEOUT_CYC-1. Neither counter wraps; both clear on every state change.
// TESTING
//  (Bench uses BAUD_DIV=16, GAP_BITS=1, TIMEOUT_CYC=1000.)
//  1. Normal transaction:
//     - Stimulus: start with A=8'h3C, B=8'hA5. A bench UART model decodes host_tx and replies 8'h5A on host_rx,
//       200 cycles after B's stop bit.
//     - Required: decoded bytes 3C then A5; A's start bit lasts exactly 16 cycles; 16 idle cycles between the two
//       frames; done pulses once; result=8'h5A.
//  2. Timeout:
//     - Stimulus: same as test 1, but host_rx is held high.
//     - Required: timeout pulses exactly 1000 cycles after WAIT_RX entry; done=0; busy=0 in the next cycle.
//  3. Framing error:
//     - Stimulus: reply 8'hFF with the stop bit driven 0, then a line return to 1.
//     - Required: frame_err pulses; result keeps its prior value (8'h5A after test 1); done=0.
//  4. Glitch rejection:
//     - Stimulus: a 3-cycle low pulse on host_rx in WAIT_RX, then a valid 8'h81 reply.
//     - Required: one done with result=8'h81; no frame_err.
//  5. Reset mid-frame and start handling:
//     - Stimulus: assert rst during bit 4 of A.
//     - Required: host_tx=1 and busy=0 the same cycle rst rises.
//     - Stimulus: after release, pulse start while busy.
//     - Required: no second transaction; exactly 20 bit-frames on host_tx.

Source files
------------

// File: rtl/uart_host_driver_if.sv
// Host UART driver bus: operand request, both serial lines, and the result/status strobes.
interface uart_host_driver_if;
    logic       start;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       host_tx;
    logic       host_rx;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       timeout;
    logic       frame_err;

    modport master (
        output start, operand_a, operand_b, host_rx,
        input  host_tx, busy, done, result, timeout, frame_err
    );

    modport slave (
        input  start, operand_a, operand_b, host_rx,
        output host_tx, busy, done, result, timeout, frame_err
    );
endinterface

// File: rtl/uart_host_driver.sv
// Sends operand A then B as 8N1 frames, then waits for and receives a one-byte reply (done/timeout/frame_err).
// Latency: first start bit one cycle after an accepted start; no backpressure, start is ignored unless IDLE.
module uart_host_driver #(
    parameter int BAUD_DIV    = 5208,
    parameter int GAP_BITS    = 1,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    uart_host_driver_if.slave bus
);
    localparam int CNT_W   = $clog2(BAUD_DIV);
    localparam int TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int IDX_MAX = (GAP_BITS > 10) ? GAP_BITS : 10;
    localparam int IDX_W   = $clog2(IDX_MAX);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [IDX_W-1:0] STOP_IDX  = IDX_W'(9);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_A,
        S_GAP,
        S_TX_B,
        S_WAIT_RX,
        S_RX
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       op_b_q, op_b_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       result_q, result_d;
    logic             host_tx_q, host_tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             frame_err_q, frame_err_d;
    logic             need_high_q, need_high_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;

    logic             bit_end;
    logic             rx_fall;
    logic             sample_pt;
    logic [TMO_W-1:0] tmo_inc;

    always_comb begin
        rx_meta_d = bus.host_rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;

        bit_end   = (cnt_q == BIT_LAST);
        rx_fall   = rx_prev_q & ~rx_sync_q;
        sample_pt = (idx_q == '0) ? (cnt_q == HALF_LAST) : bit_end;
        tmo_inc   = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;

        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tx_shift_d  = tx_shift_q;
        op_b_d      = op_b_q;
        tmo_d       = tmo_q;
        rx_shift_d  = rx_shift_q;
        result_d    = result_q;
        host_tx_d   = host_tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        frame_err_d = 1'b0;
        // After a framing error the line must be seen idle before a new request is honoured.
        need_high_d = need_high_q & ~rx_sync_q;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                idx_d     = '0;
                tmo_d     = '0;
                host_tx_d = 1'b1;
                busy_d    = 1'b0;
                if (bus.start && !need_high_q) begin
                    tx_shift_d = {1'b1, bus.operand_a, 1'b0};
                    op_b_d     = bus.operand_b;
                    host_tx_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_TX_A;
                end
            end

            S_TX_A, S_TX_B: begin
                if (!bit_end) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (idx_q != STOP_IDX) begin
                    cnt_d      = '0;
                    idx_d      = idx_q + 1'b1;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    host_tx_d  = tx_shift_q[1];
                end else begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (state_q == S_TX_B) begin
                        tmo_d     = '0;
                        host_tx_d = 1'b1;
                        state_d   = S_WAIT_RX;
                    end else if (GAP_BITS == 0) begin
                        tx_shift_d = {1'b1, op_b_q, 1'b0};
                        host_tx_d  = 1'b0;
                        state_d    = S_TX_B;
                    end else begin
                        host_tx_d = 1'b1;
                        state_d   = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (!bit_end) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (idx_q == GAP_LAST) begin
                        idx_d      = '0;
                        tx_shift_d = {1'b1, op_b_q, 1'b0};
                        host_tx_d  = 1'b0;
                        state_d    = S_TX_B;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_WAIT_RX: begin
                if (rx_fall) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tmo_d   = tmo_inc;
                    state_d = S_RX;
                end else if (tmo_q >= TMO_LAST) begin
                    tmo_d     = '0;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_RX: begin
                // A rejected start glitch returns to WAIT_RX, so the reply deadline keeps running here.
                if (idx_q == '0) begin
                    tmo_d = tmo_inc;
                end
                if (!sample_pt) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        if (rx_sync_q) begin
                            state_d = S_WAIT_RX;
                        end else begin
                            idx_d = IDX_W'(1);
                        end
                    end else if (idx_q != STOP_IDX) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        idx_d      = idx_q + 1'b1;
                    end else begin
                        idx_d   = '0;
                        tmo_d   = '0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                        if (rx_sync_q) begin
                            result_d = rx_shift_q;
                            done_d   = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            need_high_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            tx_shift_q  <= '0;
            op_b_q      <= '0;
            tmo_q       <= '0;
            rx_shift_q  <= '0;
            result_q    <= '0;
            host_tx_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            frame_err_q <= 1'b0;
            need_high_q <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tx_shift_q  <= tx_shift_d;
            op_b_q      <= op_b_d;
            tmo_q       <= tmo_d;
            rx_shift_q  <= rx_shift_d;
            result_q    <= result_d;
            host_tx_q   <= host_tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            frame_err_q <= frame_err_d;
            need_high_q <= need_high_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
        end
    end

    assign bus.host_tx   = host_tx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.timeout   = timeout_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_host_driver.sv
// Bench for uart_host_driver: serial decoder and reply model on the lines, result strobes checked by a scoreboard.
module tb_uart_host_driver;
    localparam int BD  = 16;
    localparam int GB  = 1;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_host_driver_if bus();

    uart_host_driver #(
        .BAUD_DIV   (BD),
        .GAP_BITS   (GB),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef enum int {EV_DONE, EV_TMO, EV_FERR} ev_t;
    typedef struct { ev_t kind; logic [7:0] res; int dly; } exp_ev_t;
    typedef struct { logic [7:0] data; int gap; } exp_tx_t;

    exp_ev_t ev_q[$];
    exp_tx_t tx_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int frames = 0;
    int tx_end_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decodes each frame on host_tx: every bit must hold for BD cycles; idle run before it is the inter-frame gap.
    initial begin : tx_mon
        logic       s [0:159];
        int         idle;
        logic       abort;
        logic       ok;
        logic [7:0] b;
        exp_tx_t    e;
        idle = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                idle = 0;
            end else if (bus.host_tx === 1'b1) begin
                idle++;
            end else begin
                abort = 1'b0;
                for (int i = 0; i < 160; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                    s[i] = bus.host_tx;
                end
                if (!abort) begin
                    frames++;
                    tx_end_cyc = cyc;
                    ok = 1'b1;
                    b  = 8'h00;
                    for (int k = 0; k < 10; k++)
                        for (int c = 1; c < BD; c++)
                            if (s[k*BD+c] !== s[k*BD]) ok = 1'b0;
                    if (s[0] !== 1'b0 || s[9*BD] !== 1'b1) ok = 1'b0;
                    for (int k = 0; k < 8; k++) b[k] = s[(k+1)*BD];
                    if (tx_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_unexpected: got frame %02h, expected no frame", b);
                    end else begin
                        e = tx_q.pop_front();
                        check("tx_byte", 32'(b), 32'(e.data));
                        check("tx_bit_timing", 32'(ok), 32'd1);
                        if (e.gap >= 0) check("tx_gap", 32'(idle), 32'(e.gap));
                    end
                end
                idle = 0;
            end
        end
    end

    // Pops the expected outcome whenever any result strobe fires.
    initial begin : ev_mon
        exp_ev_t e;
        int      n;
        logic    chk_next;
        chk_next = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_next) begin
                check("busy_after_pulse", 32'(bus.busy), 32'd0);
                chk_next = 1'b0;
            end
            n = int'(bus.done) + int'(bus.timeout) + int'(bus.frame_err);
            if (n != 0) begin
                chk_next = 1'b1;
                check("one_pulse", 32'(n), 32'd1);
                check("busy_at_pulse", 32'(bus.busy), 32'd0);
                if (ev_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ev_unexpected: got done=%0b timeout=%0b frame_err=%0b, expected none",
                             bus.done, bus.timeout, bus.frame_err);
                end else begin
                    e = ev_q.pop_front();
                    check("ev_done", 32'(bus.done), 32'(e.kind == EV_DONE));
                    check("ev_timeout", 32'(bus.timeout), 32'(e.kind == EV_TMO));
                    check("ev_frame_err", 32'(bus.frame_err), 32'(e.kind == EV_FERR));
                    check("ev_result", 32'(bus.result), 32'(e.res));
                    if (e.dly >= 0) check("ev_latency", 32'(cyc - tx_end_cyc), 32'(e.dly));
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_txn(input logic [7:0] a, input logic [7:0] b);
        tx_q.push_back('{data: a, gap: -1});
        tx_q.push_back('{data: b, gap: GB * BD});
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (frames < target) begin
            total++;
            bad++;
            $display("FAIL wait_frames: got %0d frames, expected %0d", frames, target);
        end
    endtask

    task automatic wait_drained();
        int t;
        t = 0;
        while (ev_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (ev_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL wait_event: got %0d outstanding, expected 0", ev_q.size());
            ev_q.delete();
        end
        wait_cycles(10);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bus.host_rx = f[k];
            repeat (BD) @(negedge clk);
        end
        bus.host_rx = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1);
    end

    initial begin : stim
        int base;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.operand_a = 8'h00;
        bus.operand_b = 8'h00;
        bus.host_rx   = 1'b1;
        wait_cycles(3);
        check("rst_host_tx", 32'(bus.host_tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        rst = 1'b0;
        wait_cycles(5);

        // Normal transaction, reply 200 cycles after B's stop bit.
        ev_q.push_back('{kind: EV_DONE, res: 8'h5A, dly: -1});
        start_txn(8'h3C, 8'hA5);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        wait_frames(2);
        wait_cycles(200);
        send_rx(8'h5A, 1'b1);
        wait_drained();

        // Silent line: timeout 1000 cycles after WAIT_RX entry, which is the cycle after B's last stop cycle.
        ev_q.push_back('{kind: EV_TMO, res: 8'h5A, dly: TMO + 1});
        start_txn(8'h3C, 8'hA5);
        wait_frames(4);
        wait_drained();

        // Stop bit low: result keeps the previous byte.
        ev_q.push_back('{kind: EV_FERR, res: 8'h5A, dly: -1});
        start_txn(8'h3C, 8'hA5);
        wait_frames(6);
        wait_cycles(50);
        send_rx(8'hFF, 1'b0);
        wait_drained();
        wait_cycles(20);

        // Short low pulse must be rejected, then a real reply accepted.
        ev_q.push_back('{kind: EV_DONE, res: 8'h81, dly: -1});
        start_txn(8'h3C, 8'hA5);
        wait_frames(8);
        wait_cycles(40);
        bus.host_rx = 1'b0;
        wait_cycles(3);
        bus.host_rx = 1'b1;
        wait_cycles(40);
        send_rx(8'h81, 1'b1);
        wait_drained();

        // Reset during bit 4 of A (frame cycles 64..79).
        start_txn(8'h3C, 8'hA5);
        wait_cycles(70);
        check("busy_before_rst", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_host_tx", 32'(bus.host_tx), 32'd1);
        check("rst_async_busy", 32'(bus.busy), 32'd0);
        wait_cycles(3);
        rst = 1'b0;
        tx_q.delete();
        check("result_after_rst", 32'(bus.result), 32'd0);
        wait_cycles(5);

        // A start pulse while busy must not launch another transaction.
        base = frames;
        ev_q.push_back('{kind: EV_TMO, res: 8'h00, dly: TMO + 1});
        start_txn(8'h12, 8'h34);
        wait_cycles(20);
        bus.start     = 1'b1;
        bus.operand_a = 8'hFE;
        bus.operand_b = 8'hEF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_frames(base + 2);
        wait_drained();
        wait_cycles(400);
        check("frame_count", 32'(frames - base), 32'd2);
        check("tx_left", 32'(tx_q.size()), 32'd0);
        check("ev_left", 32'(ev_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
